mul_pipe: RTL and testbench

//  Pipelined RV64M multiply unit; sits directly downstream of the multiply issue queue.

---
 rtl/mul_pipe_pkg.sv | 51 +++++
 rtl/mul_pipe_stage_reg.sv | 38 +++
 rtl/mul_pipe.sv | 116 +++++++++++
 tb/tb_mul_pipe.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pipe_pkg.sv
// rtl/mul_pipe_pkg.sv - shared types for the pipelined RV64M multiply unit
package mul_pipe_pkg;

    localparam int XLEN   = 64;
    localparam int PREG_W = 6;
    localparam int ROB_W  = 5;
    localparam int STAGES = 3;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_MULW   = 3'd4
    } mul_op_t;

    typedef struct packed {
        mul_op_t             op;
        logic [XLEN-1:0]     src1;
        logic [XLEN-1:0]     src2;
        logic [PREG_W-1:0]   dst;
        logic [ROB_W-1:0]    rob;
    } mul_req_t;

    typedef struct packed {
        logic [XLEN-1:0]     data;
        logic [PREG_W-1:0]   dst;
        logic [ROB_W-1:0]    rob;
    } mul_resp_t;

    // Stage 0 payload: operands extended to 65-bit two's complement.
    typedef struct packed {
        mul_op_t             op;
        logic [XLEN:0]       a;
        logic [XLEN:0]       b;
        logic [PREG_W-1:0]   dst;
        logic [ROB_W-1:0]    rob;
    } mul_ext_t;

    // Stage 1 payload; hh keeps only the bits that land below bit 128.
    typedef struct packed {
        mul_op_t             op;
        logic [63:0]         ll;
        logic [65:0]         lh;
        logic [65:0]         hl;
        logic [63:0]         hh;
        logic [PREG_W-1:0]   dst;
        logic [ROB_W-1:0]    rob;
    } mul_pp_t;

endpackage

// File: rtl/mul_pipe_stage_reg.sv
// rtl/mul_pipe_stage_reg.sv - one elastic valid/ready pipeline register with flush
module mul_stage_reg #(
    parameter type T = logic [0:0]
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic valid;
    T     data;

    // Empty slots always accept, so bubbles collapse; flush blocks acceptance.
    assign in_ready  = (!valid || out_ready) && !flush;
    assign out_valid = valid;
    assign out_data  = data;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (!valid || out_ready) begin
            valid <= in_valid;
            if (in_valid) begin
                data <= in_data;
            end
        end
    end

endmodule

// File: rtl/mul_pipe.sv
// rtl/mul_pipe.sv - three-stage elastic RV64M multiplier (prep, partial products, sum/select)
module mul_pipe
    import mul_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [XLEN-1:0]   in_src1,
    input  logic [XLEN-1:0]   in_src2,
    input  logic [PREG_W-1:0] in_dst,
    input  logic [ROB_W-1:0]  in_rob,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic [PREG_W-1:0] out_dst,
    output logic [ROB_W-1:0]  out_rob,
    output logic              busy
);

    mul_req_t  req;
    mul_ext_t  ext_d, ext_q;
    mul_pp_t   pp_d, pp_q;
    mul_resp_t resp_d, resp_q;
    logic      v0, v1, v2, r1, r2;

    assign req = '{op: mul_op_t'(in_op), src1: in_src1, src2: in_src2, dst: in_dst, rob: in_rob};

    always_comb begin
        ext_d     = '0;
        ext_d.op  = req.op;
        ext_d.dst = req.dst;
        ext_d.rob = req.rob;
        ext_d.a   = {1'b0, req.src1};
        ext_d.b   = {1'b0, req.src2};
        case (req.op)
            OP_MULH: begin
                ext_d.a = {req.src1[XLEN-1], req.src1};
                ext_d.b = {req.src2[XLEN-1], req.src2};
            end
            OP_MULHSU: ext_d.a = {req.src1[XLEN-1], req.src1};
            OP_MULW: begin
                ext_d.a = {33'd0, req.src1[31:0]};
                ext_d.b = {33'd0, req.src2[31:0]};
            end
            default: ;
        endcase
    end

    mul_stage_reg #(.T(mul_ext_t)) u_s0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(ext_d),
        .out_valid(v0), .out_ready(r1), .out_data(ext_q)
    );

    // 65x65 split as signed 33-bit high half and unsigned 32-bit low half.
    logic signed [32:0] ah, bh;
    logic [31:0]        al, bl;
    logic signed [65:0] hh_full;

    always_comb begin
        ah        = $signed(ext_q.a[64:32]);
        bh        = $signed(ext_q.b[64:32]);
        al        = ext_q.a[31:0];
        bl        = ext_q.b[31:0];
        hh_full   = 66'(ah) * 66'(bh);
        pp_d      = '0;
        pp_d.op   = ext_q.op;
        pp_d.dst  = ext_q.dst;
        pp_d.rob  = ext_q.rob;
        pp_d.ll   = 64'(al) * 64'(bl);
        pp_d.lh   = 66'($signed({1'b0, al})) * 66'(bh);
        pp_d.hl   = 66'(ah) * 66'($signed({1'b0, bl}));
        pp_d.hh   = hh_full[63:0];
    end

    mul_stage_reg #(.T(mul_pp_t)) u_s1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(v0), .in_ready(r1), .in_data(pp_d),
        .out_valid(v1), .out_ready(r2), .out_data(pp_q)
    );

    // Sum modulo 2^128: the upper bits of the 130-bit product never reach any result.
    logic [127:0] prod;

    always_comb begin
        prod = {64'd0, pp_q.ll}
             + (128'($signed(pp_q.lh)) << 32)
             + (128'($signed(pp_q.hl)) << 32)
             + {pp_q.hh, 64'd0};
        resp_d     = '0;
        resp_d.dst = pp_q.dst;
        resp_d.rob = pp_q.rob;
        case (pp_q.op)
            OP_MUL:                        resp_d.data = prod[63:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  resp_d.data = prod[127:64];
            OP_MULW:                       resp_d.data = {{32{prod[31]}}, prod[31:0]};
            default:                       resp_d.data = '0;
        endcase
    end

    mul_stage_reg #(.T(mul_resp_t)) u_s2 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(v1), .in_ready(r2), .in_data(resp_d),
        .out_valid(v2), .out_ready(out_ready), .out_data(resp_q)
    );

    assign out_valid = v2;
    assign out_data  = resp_q.data;
    assign out_dst   = resp_q.dst;
    assign out_rob   = resp_q.rob;
    assign busy      = v0 | v1 | v2;

endmodule

// File: tb/tb_mul_pipe.sv
// tb/tb_mul_pipe.sv - self-checking bench for mul_pipe with a reference multiply model
module tb_mul_pipe;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [2:0]  in_op;
    logic [63:0] in_src1, in_src2;
    logic [5:0]  in_dst;
    logic [4:0]  in_rob;
    logic        in_ready, out_valid, busy;
    logic [63:0] out_data;
    logic [5:0]  out_dst;
    logic [4:0]  out_rob;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [63:0] exp_data[$];
    logic [5:0]  exp_dst[$];
    logic [4:0]  exp_rob[$];
    int          acc_cyc[$];
    logic [63:0] ret_data[$];
    logic [5:0]  ret_dst[$];
    logic [4:0]  ret_rob[$];
    int          ret_cyc[$];
    int          ret_lat[$];

    mul_pipe dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .in_dst(in_dst), .in_rob(in_rob),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_dst(out_dst), .out_rob(out_rob), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] x, y, p;
        logic [63:0]  w;
        x = {64'd0, a};
        y = {64'd0, b};
        if (op == 3'd1 || op == 3'd2) x = {{64{a[63]}}, a};
        if (op == 3'd1) y = {{64{b[63]}}, b};
        p = x * y;
        w = {32'd0, a[31:0]} * {32'd0, b[31:0]};
        case (op)
            3'd0:             return p[63:0];
            3'd1, 3'd2, 3'd3: return p[127:64];
            3'd4:             return {{32{w[31]}}, w[31:0]};
            default:          return 64'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    logic        hold = 1'b0;
    logic [63:0] hold_data;
    logic [4:0]  hold_rob;

    always @(negedge clk) begin
        if (reset || flush) begin
            exp_data.delete(); exp_dst.delete(); exp_rob.delete(); acc_cyc.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", {63'd0, out_valid}, 64'd1);
                check("hold_data", out_data, hold_data);
                check("hold_rob", {59'd0, out_rob}, {59'd0, hold_rob});
            end
            if (out_valid && out_ready) begin
                if (exp_data.size() == 0) begin
                    check("spurious_out_valid", 64'd1, 64'd0);
                end else begin
                    check("out_data", out_data, exp_data.pop_front());
                    check("out_dst", {58'd0, out_dst}, {58'd0, exp_dst.pop_front()});
                    check("out_rob", {59'd0, out_rob}, {59'd0, exp_rob.pop_front()});
                    ret_data.push_back(out_data);
                    ret_dst.push_back(out_dst);
                    ret_rob.push_back(out_rob);
                    ret_cyc.push_back(cyc);
                    ret_lat.push_back(cyc - acc_cyc.pop_front());
                end
            end
            hold      = out_valid && !out_ready;
            hold_data = out_data;
            hold_rob  = out_rob;
            if (in_valid && in_ready) begin
                exp_data.push_back(model(in_op, in_src1, in_src2));
                exp_dst.push_back(in_dst);
                exp_rob.push_back(in_rob);
                acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        ret_data.delete(); ret_dst.delete(); ret_rob.delete(); ret_cyc.delete(); ret_lat.delete();
    endtask

    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [5:0] dst, input logic [4:0] rob);
        logic acc;
        int   n;
        in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_dst = dst; in_rob = rob;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) check("issue_timeout", 64'd1, 64'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_data.size() != 0 || busy) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic check_consecutive(input string name);
        for (int i = 1; i < ret_cyc.size(); i++)
            check(name, 64'(ret_cyc[i] - ret_cyc[i-1]), 64'd1);
    endtask

    logic [2:0]  t_op[12]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd2, 3'd0, 3'd4, 3'd7, 3'd3};
    logic [63:0] t_a[12]   = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                               64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_8000_0000, 64'd9,
                               64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFFF,
                               64'h0000_0001_0001_0001, 64'd1, 64'h0};
    logic [63:0] t_b[12]   = '{64'h2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                               64'h0FED_CBA9_8765_4321, 64'h0000_0000_8000_0000, 64'd9,
                               64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                               64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 3'd0; in_src1 = '0; in_src2 = '0; in_dst = '0; in_rob = '0;
        tick(); tick(); tick();
        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_dst", {58'd0, out_dst}, 64'd0);
        check("rst_out_rob", {59'd0, out_rob}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        reset = 1'b0;

        // Single MUL with latency
        clear_log();
        out_ready = 1'b1;
        issue(3'd0, 64'd3, 64'd5, 6'd7, 5'd2);
        drain();
        check("t1_count", 64'(ret_data.size()), 64'd1);
        if (ret_data.size() == 1) begin
            check("t1_data", ret_data[0], 64'd15);
            check("t1_dst", {58'd0, ret_dst[0]}, 64'd7);
            check("t1_rob", {59'd0, ret_rob[0]}, 64'd2);
            check("t1_latency", 64'(ret_lat[0]), 64'd3);
        end

        // Hand-computed high-half and word results, streamed back-to-back
        clear_log();
        issue(3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0, 5'd3);
        issue(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd1, 5'd4);
        issue(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd2, 5'd5);
        issue(3'd4, 64'h7FFF_FFFF, 64'd2, 6'd3, 5'd6);
        drain();
        check("t23_count", 64'(ret_data.size()), 64'd4);
        if (ret_data.size() == 4) begin
            check("t2_mulh", ret_data[0], 64'd0);
            check("t2_mulhu", ret_data[1], 64'hFFFF_FFFF_FFFF_FFFE);
            check("t3_mulhsu", ret_data[2], 64'hFFFF_FFFF_FFFF_FFFF);
            check("t3_mulw", ret_data[3], 64'hFFFF_FFFF_FFFF_FFFE);
            check("t2_dst0", {58'd0, ret_dst[0]}, 64'd0);
        end
        check_consecutive("t23_gap");

        // Boundary table, including reserved ops, checked by the model
        clear_log();
        for (int i = 0; i < 12; i++) issue(t_op[i], t_a[i], t_b[i], 6'(i + 8), 5'(i));
        drain();
        check("tbl_count", 64'(ret_data.size()), 64'd12);

        // Backpressure: three accepts fill the pipe, fourth waits
        clear_log();
        out_ready = 1'b0;
        issue(3'd0, 64'd10, 64'd10, 6'd10, 5'd10);
        issue(3'd0, 64'd11, 64'd11, 6'd11, 5'd11);
        issue(3'd0, 64'd12, 64'd12, 6'd12, 5'd12);
        in_valid = 1'b1; in_op = 3'd0; in_src1 = 64'd13; in_src2 = 64'd13; in_dst = 6'd13; in_rob = 5'd13;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t4_in_ready_low", {63'd0, in_ready}, 64'd0);
            check("t4_busy", {63'd0, busy}, 64'd1);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_in_ready_release", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        drain();
        check("t4_count", 64'(ret_rob.size()), 64'd4);
        for (int i = 0; i < ret_rob.size(); i++) check("t4_order", {59'd0, ret_rob[i]}, 64'(10 + i));
        check_consecutive("t4_gap");

        // Bubble collapse
        clear_log();
        out_ready = 1'b0;
        issue(3'd0, 64'd20, 64'd2, 6'd20, 5'd20);
        tick();
        issue(3'd0, 64'd21, 64'd2, 6'd21, 5'd21);
        tick(); tick(); tick();
        out_ready = 1'b1;
        drain();
        check("t5_count", 64'(ret_rob.size()), 64'd2);
        check_consecutive("t5_gap");

        // Flush with two uops in flight
        clear_log();
        out_ready = 1'b0;
        issue(3'd0, 64'd4, 64'd4, 6'd30, 5'd30);
        issue(3'd0, 64'd5, 64'd5, 6'd31, 5'd31);
        flush = 1'b1;
        @(negedge clk);
        check("t6_flush_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t6_flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("t6_flush_busy", {63'd0, busy}, 64'd0);
        for (int i = 0; i < 4; i++) tick();
        check("t6_flush_retired", 64'(ret_rob.size()), 64'd0);

        // Reset mid-operation
        issue(3'd0, 64'd6, 64'd6, 6'd25, 5'd25);
        issue(3'd0, 64'd7, 64'd7, 6'd26, 5'd26);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t6_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("t6_rst_out_data", out_data, 64'd0);
        check("t6_rst_out_dst", {58'd0, out_dst}, 64'd0);
        check("t6_rst_out_rob", {59'd0, out_rob}, 64'd0);
        check("t6_rst_busy", {63'd0, busy}, 64'd0);
        for (int i = 0; i < 5; i++) tick();
        check("t6_rst_retired", 64'(ret_rob.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
